// File: rtl/lsu_vec.sv
// Vector load-store unit: moves VEC_LEN consecutive elements per LOAD/STR over a valid/ready memory port.
// Latency: 1 + 2*VEC_LEN clocks from the start edge to LSU_DONE when ready answers immediately.
// Backpressure: each request holds valid/addr/data until its ready; an optional timeout aborts a stalled element.
package gpu_pkg;
    typedef enum logic [2:0] {
        CORE_IDLE, CORE_FETCH, CORE_DECODE, CORE_REQUEST,
        CORE_WAIT, CORE_EXECUTE, CORE_UPDATE, CORE_DONE
    } core_state_t;
    typedef enum logic [1:0] {
        LSU_IDLE, LSU_REQUESTING, LSU_WAITING, LSU_DONE
    } lsu_state_t;
endpackage

module lsu_vec
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int VEC_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  core_state_t                   core_state,
    input  logic                          mem_read_en,
    input  logic                          mem_write_en,
    input  logic [DATA_WIDTH-1:0]         rs_data,
    input  logic [VEC_LEN*DATA_WIDTH-1:0] rt_vec,
    output logic                          mem_read_valid,
    output logic [ADDR_WIDTH-1:0]         mem_read_addr,
    input  logic                          mem_read_ready,
    input  logic [DATA_WIDTH-1:0]         mem_read_data,
    output logic                          mem_write_valid,
    output logic [ADDR_WIDTH-1:0]         mem_write_addr,
    output logic [DATA_WIDTH-1:0]         mem_write_data,
    input  logic                          mem_write_ready,
    output lsu_state_t                    lsu_state,
    output logic [VEC_LEN*DATA_WIDTH-1:0] lsu_out,
    output logic                          lsu_err
);
    localparam int VW   = VEC_LEN * DATA_WIDTH;
    localparam int MW   = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;
    localparam int IW   = ($clog2(VEC_LEN + 1) < 1) ? 1 : $clog2(VEC_LEN + 1);
    localparam int TW   = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [IW-1:0] LAST = IW'(VEC_LEN - 1);

    lsu_state_t            state_q, state_n;
    logic                  is_wr_q, is_wr_n;
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [VW-1:0]         wdata_q, wdata_n;
    logic [IW-1:0]         idx_q, idx_n;
    logic [TW-1:0]         tcnt_q, tcnt_n;
    logic [VW-1:0]         out_q, out_n;
    logic                  err_q, err_n;
    logic                  rvld_q, rvld_n;
    logic                  wvld_q, wvld_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_n;
    logic [MW-1:0]         rs_ext;
    logic                  el_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            is_wr_q <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            rvld_q  <= 1'b0;
            wvld_q  <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
        end else if (enable) begin
            state_q <= state_n;
            is_wr_q <= is_wr_n;
            base_q  <= base_n;
            wdata_q <= wdata_n;
            idx_q   <= idx_n;
            tcnt_q  <= tcnt_n;
            out_q   <= out_n;
            err_q   <= err_n;
            rvld_q  <= rvld_n;
            wvld_q  <= wvld_n;
            addr_q  <= addr_n;
            wdat_q  <= wdat_n;
        end
    end

    always_comb begin
        state_n = state_q;
        is_wr_n = is_wr_q;
        base_n  = base_q;
        wdata_n = wdata_q;
        idx_n   = idx_q;
        tcnt_n  = tcnt_q;
        out_n   = out_q;
        err_n   = err_q;
        rvld_n  = rvld_q;
        wvld_n  = wvld_q;
        addr_n  = addr_q;
        wdat_n  = wdat_q;
        rs_ext  = MW'(rs_data);
        el_rdy  = is_wr_q ? mem_write_ready : mem_read_ready;
        case (state_q)
            LSU_IDLE: begin
                if (core_state == CORE_REQUEST) begin
                    if (mem_read_en && mem_write_en) begin
                        err_n   = 1'b1;
                        state_n = LSU_DONE;
                    end else if (mem_read_en || mem_write_en) begin
                        is_wr_n = mem_write_en;
                        base_n  = rs_ext[ADDR_WIDTH-1:0];
                        wdata_n = rt_vec;
                        idx_n   = '0;
                        err_n   = 1'b0;
                        if (mem_read_en) out_n = '0;
                        state_n = LSU_REQUESTING;
                    end
                end
            end
            LSU_REQUESTING: begin
                addr_n  = base_q + ADDR_WIDTH'(idx_q);
                wdat_n  = wdata_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
                rvld_n  = !is_wr_q;
                wvld_n  = is_wr_q;
                tcnt_n  = '0;
                state_n = LSU_WAITING;
            end
            LSU_WAITING: begin
                // ready is checked before the timeout so a same-cycle answer still completes
                if (el_rdy) begin
                    rvld_n = 1'b0;
                    wvld_n = 1'b0;
                    if (!is_wr_q) out_n[idx_q*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
                    if (idx_q == LAST) begin
                        state_n = LSU_DONE;
                    end else begin
                        idx_n   = idx_q + 1'b1;
                        state_n = LSU_REQUESTING;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    tcnt_n = tcnt_q + 1'b1;
                    if (tcnt_q == TW'(TLIM)) begin
                        rvld_n  = 1'b0;
                        wvld_n  = 1'b0;
                        err_n   = 1'b1;
                        state_n = LSU_DONE;
                    end
                end
            end
            LSU_DONE: begin
                if (core_state == CORE_UPDATE) state_n = LSU_IDLE;
            end
            default: state_n = LSU_IDLE;
        endcase
    end

    assign mem_read_valid  = rvld_q;
    assign mem_read_addr   = addr_q;
    assign mem_write_valid = wvld_q;
    assign mem_write_addr  = addr_q;
    assign mem_write_data  = wdat_q;
    assign lsu_state       = state_q;
    assign lsu_out         = out_q;
    assign lsu_err         = err_q;
endmodule

// File: tb/tb_lsu_vec.sv
// Directed bench for lsu_vec: vector load/store, address wrap, timeout, illegal op, enable freeze, async reset.
// A negedge memory responder answers requests and logs them; expected values are hand-computed constants.
module tb_lsu_vec;
    import gpu_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int VL = 4;
    localparam int TO = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    core_state_t       core_state = CORE_IDLE;
    logic              mem_read_en = 1'b0;
    logic              mem_write_en = 1'b0;
    logic [DW-1:0]     rs_data = '0;
    logic [VL*DW-1:0]  rt_vec = '0;
    logic              mem_read_valid;
    logic [AW-1:0]     mem_read_addr;
    logic              mem_read_ready = 1'b0;
    logic [DW-1:0]     mem_read_data = '0;
    logic              mem_write_valid;
    logic [AW-1:0]     mem_write_addr;
    logic [DW-1:0]     mem_write_data;
    logic              mem_write_ready = 1'b0;
    lsu_state_t        lsu_state;
    logic [VL*DW-1:0]  lsu_out;
    logic              lsu_err;

    int n_chk = 0;
    int n_err = 0;

    lsu_vec #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VEC_LEN(VL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .core_state(core_state),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .rs_data(rs_data), .rt_vec(rt_vec),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_err(lsu_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory responder: answers after rd_delay/wr_delay negedges unless the address is blocked
    int            rd_delay = 0, wr_delay = 0;
    logic          rd_block_en = 1'b0, wr_block_en = 1'b0;
    logic [AW-1:0] rd_block = '0, wr_block = '0;
    int            rd_cnt = 0, wr_cnt = 0, rd_reqs = 0, wr_reqs = 0, stab_err = 0, hi_len = 0;
    logic [AW-1:0] rd_log[$];
    logic [AW-1:0] wr_alog[$];
    logic [DW-1:0] wr_dlog[$];
    logic          prv_rv = 1'b0, prv_wv = 1'b0;
    logic [AW-1:0] h_ra = '0, h_wa = '0;
    logic [DW-1:0] h_wd = '0;

    always @(negedge clk) begin
        if (mem_read_valid) begin
            if (!prv_rv) begin
                rd_reqs++;
                rd_log.push_back(mem_read_addr);
                h_ra   = mem_read_addr;
                rd_cnt = 0;
                hi_len = 0;
            end else if (mem_read_addr != h_ra) stab_err++;
            hi_len++;
            if (!(rd_block_en && mem_read_addr == rd_block) && rd_cnt >= rd_delay) begin
                mem_read_ready = 1'b1;
                mem_read_data  = 8'hA0 + mem_read_addr;
            end
            rd_cnt++;
        end else mem_read_ready = 1'b0;
        prv_rv = mem_read_valid;
        if (mem_write_valid) begin
            if (!prv_wv) begin
                wr_reqs++;
                wr_alog.push_back(mem_write_addr);
                wr_dlog.push_back(mem_write_data);
                h_wa   = mem_write_addr;
                h_wd   = mem_write_data;
                wr_cnt = 0;
            end else if (mem_write_addr != h_wa || mem_write_data != h_wd) stab_err++;
            if (!(wr_block_en && mem_write_addr == wr_block) && wr_cnt >= wr_delay)
                mem_write_ready = 1'b1;
            wr_cnt++;
        end else mem_write_ready = 1'b0;
        prv_wv = mem_write_valid;
    end

    task automatic clear_logs();
        rd_log.delete(); wr_alog.delete(); wr_dlog.delete();
        rd_reqs = 0; wr_reqs = 0; stab_err = 0;
    endtask

    // cyc counts negedges after the start edge until LSU_DONE is seen (start edge counted as 1)
    task automatic run_op(input logic rd, input logic wr, input logic [DW-1:0] base,
                          input logic [VL*DW-1:0] vec, input int frz, input int budget,
                          output int cyc);
        clear_logs();
        @(negedge clk);
        core_state = CORE_REQUEST; mem_read_en = rd; mem_write_en = wr;
        rs_data = base; rt_vec = vec;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                core_state = CORE_WAIT; mem_read_en = 1'b0; mem_write_en = 1'b0;
                rs_data = 8'h5A; rt_vec = ~vec;
            end
            if (frz > 0 && cyc > frz && cyc <= frz + 3) begin
                chk("frz_state", lsu_state, LSU_WAITING);
                chk("frz_addr", mem_read_addr, base);
                chk("frz_valid", mem_read_valid, 1'b1);
            end
            if (frz > 0 && cyc == frz) enable = 1'b0;
            if (frz > 0 && cyc == frz + 3) enable = 1'b1;
        end while (lsu_state != LSU_DONE && cyc < budget);
    endtask

    task automatic do_update(input string tag);
        core_state = CORE_UPDATE;
        @(negedge clk);
        core_state = CORE_WAIT;
        chk(tag, lsu_state, LSU_IDLE);
    endtask

    initial begin
        int cyc;
        int n;
        logic [AW-1:0] st_a[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [DW-1:0] st_d[4] = '{8'h01, 8'h02, 8'h03, 8'h04};

        repeat (3) @(negedge clk);
        chk("rst_state", lsu_state, LSU_IDLE);
        chk("rst_rvalid", mem_read_valid, 1'b0);
        chk("rst_wvalid", mem_write_valid, 1'b0);
        chk("rst_out", lsu_out, 0);
        chk("rst_err", lsu_err, 1'b0);
        rst_n = 1'b1; enable = 1'b1;

        // vector load, ready 2 cycles late: 4 elements x (1 REQ + 3 WAIT) + start edge
        rd_delay = 2;
        run_op(1'b1, 1'b0, 8'h10, '0, 0, 60, cyc);
        chk("ld_cycles", cyc, 17);
        chk("ld_reqs", rd_reqs, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("ld_addr%0d", i), rd_log[i], 8'h10 + i);
        chk("ld_out", lsu_out, 32'hB3B2B1B0);
        chk("ld_err", lsu_err, 1'b0);
        chk("ld_stable", stab_err, 0);
        do_update("ld_idle");
        rd_delay = 0;

        // store with address wrap, immediate ready
        run_op(1'b0, 1'b1, 8'hFE, 32'h04030201, 0, 40, cyc);
        chk("st_cycles", cyc, 9);
        chk("st_reqs", wr_reqs, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("st_addr%0d", i), wr_alog[i], st_a[i]);
            chk($sformatf("st_data%0d", i), wr_dlog[i], st_d[i]);
        end
        chk("st_stable", stab_err, 0);
        chk("st_out_hold", lsu_out, 32'hB3B2B1B0);
        chk("st_err", lsu_err, 1'b0);
        do_update("st_idle");

        // both enables: straight to DONE with error, no traffic
        run_op(1'b1, 1'b1, 8'h77, '0, 0, 20, cyc);
        chk("ill_cycles", cyc, 1);
        chk("ill_state", lsu_state, LSU_DONE);
        chk("ill_err", lsu_err, 1'b1);
        chk("ill_reqs", rd_reqs + wr_reqs, 0);
        chk("ill_out_hold", lsu_out, 32'hB3B2B1B0);
        do_update("ill_idle");

        // freeze 3 cycles inside WAITING on a stalled element: timeout stretches by 3
        rd_block_en = 1'b1; rd_block = 8'h30;
        run_op(1'b1, 1'b0, 8'h30, '0, 3, 40, cyc);
        chk("frz_cycles", cyc, 10);
        chk("frz_hi_len", hi_len, 8);
        chk("frz_err", lsu_err, 1'b1);
        chk("frz_out", lsu_out, 0);
        chk("frz_reqs", rd_reqs, 1);
        do_update("frz_idle");

        // timeout on element 2: elements 0-1 kept, 2-3 zero
        rd_block = 8'h22;
        run_op(1'b1, 1'b0, 8'h20, '0, 0, 40, cyc);
        chk("to_cycles", cyc, 11);
        chk("to_hi_len", hi_len, 5);
        chk("to_err", lsu_err, 1'b1);
        chk("to_out", lsu_out, 32'h0000C1C0);
        chk("to_valid", mem_read_valid, 1'b0);
        repeat (3) @(negedge clk);
        chk("to_no_more", rd_reqs, 3);
        chk("to_hold", lsu_state, LSU_DONE);
        do_update("to_idle");
        rd_block_en = 1'b0;

        // async reset while a write is outstanding
        clear_logs();
        wr_block_en = 1'b1; wr_block = 8'h41;
        @(negedge clk);
        core_state = CORE_REQUEST; mem_write_en = 1'b1; rs_data = 8'h40; rt_vec = 32'h44332211;
        @(negedge clk);
        core_state = CORE_WAIT; mem_write_en = 1'b0;
        n = 0;
        while (!(mem_write_valid && mem_write_addr == 8'h41) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rs_pre_valid", mem_write_valid, 1'b1);
        chk("rs_pre_data", mem_write_data, 8'h22);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_valid", mem_write_valid, 1'b0);
        chk("rs_state", lsu_state, LSU_IDLE);
        chk("rs_out", lsu_out, 0);
        @(negedge clk);
        rst_n = 1'b1; wr_block_en = 1'b0;

        run_op(1'b0, 1'b1, 8'h50, 32'hDDCCBBAA, 0, 40, cyc);
        chk("post_cycles", cyc, 9);
        chk("post_reqs", wr_reqs, 4);
        chk("post_addr0", wr_alog[0], 8'h50);
        chk("post_data0", wr_dlog[0], 8'hAA);
        chk("post_addr3", wr_alog[3], 8'h53);
        chk("post_err", lsu_err, 1'b0);
        do_update("post_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
